// File: rtl/timer_bus_master_pkg.sv
// Shared types and constants for the timer register bus initiator.
package timer_bus_pkg;

    localparam logic [1:0] ADDR_STARTSTOP = 2'b00;
    localparam logic [1:0] ADDR_TIMER1    = 2'b01;
    localparam logic [1:0] ADDR_TIMER2    = 2'b10;

    localparam logic [1:0] BUS_ADDR_IDLE  = 2'b00;
    localparam logic [7:0] BUS_DATA_IDLE  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RELEASE
    } state_e;

    typedef struct packed {
        logic       write;
        logic [1:0] addr;
        logic [7:0] wdata;
    } cmd_t;

endpackage

// File: rtl/timer_bus_master_if.sv
// Command, response and register-bus signals of timer_bus_master; master = the initiator's view.
interface timer_bus_master_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;

    logic       rsp_valid;
    logic       rsp_write;
    logic [1:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic       busy;

    logic [1:0] addr;
    logic [7:0] wdata;
    logic       write;
    logic       read;
    logic [7:0] rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rdata,
        output cmd_ready, rsp_valid, rsp_write, rsp_addr, rsp_rdata, busy,
        output addr, wdata, write, read
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rdata,
        input  cmd_ready, rsp_valid, rsp_write, rsp_addr, rsp_rdata, busy,
        input  addr, wdata, write, read
    );

endinterface

// File: rtl/timer_bus_master_cmd_fifo.sv
// Synchronous command FIFO (timer_cmd_fifo); compiled only when TIMER_CMD_FIFO_EN is defined.
`ifdef TIMER_CMD_FIFO_EN
module timer_cmd_fifo
    import timer_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  cmd_t din_i,
    input  logic pop_i,
    output cmd_t dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

endmodule
`endif

// File: rtl/timer_bus_master.sv
// Timer register bus initiator: replays commands as setup/strobe/release transactions.
// Optional command FIFO enabled with `define TIMER_CMD_FIFO_EN.
module timer_bus_master
    import timer_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    timer_bus_master_if.master bus
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    state_e     state_q;
    logic       cmd_write_q;
    logic [1:0] cmd_addr_q;
    logic [1:0] addr_q;
    logic [7:0] wdata_q;
    logic       write_q;
    logic       read_q;
    logic       rsp_valid_q;
    logic       rsp_write_q;
    logic [1:0] rsp_addr_q;
    logic [7:0] rsp_rdata_q;

    cmd_t cmd_in;
    cmd_t cmd_next;
    logic cmd_avail;
    logic queued;
    logic take;

    assign cmd_in = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    assign take   = (state_q == ST_IDLE || state_q == ST_RELEASE) && cmd_avail;

`ifdef TIMER_CMD_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    timer_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.cmd_valid && !fifo_full),
        .din_i   (cmd_in),
        .pop_i   (take),
        .dout_o  (cmd_next),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_avail     = !fifo_empty;
    assign queued        = !fifo_empty;
    assign bus.cmd_ready = !fifo_full;
`else
    // Without a queue the command is taken straight from the port into the FSM.
    assign cmd_next      = cmd_in;
    assign cmd_avail     = bus.cmd_valid;
    assign queued        = 1'b0;
    assign bus.cmd_ready = (state_q == ST_IDLE || state_q == ST_RELEASE) && !rst;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= BUS_ADDR_IDLE;
            addr_q      <= BUS_ADDR_IDLE;
            wdata_q     <= BUS_DATA_IDLE;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_addr_q  <= BUS_ADDR_IDLE;
            rsp_rdata_q <= BUS_DATA_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_RELEASE: begin
                    rsp_valid_q <= 1'b0;
                    if (take) begin
                        state_q     <= ST_SETUP;
                        cmd_write_q <= cmd_next.write;
                        cmd_addr_q  <= cmd_next.addr;
                        addr_q      <= cmd_next.addr;
                        wdata_q     <= cmd_next.wdata;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_STROBE;
                    write_q <= cmd_write_q;
                    read_q  <= !cmd_write_q;
                end
                ST_STROBE: begin
                    // rdata is valid while read is high, so it is captured on this edge.
                    state_q     <= ST_RELEASE;
                    write_q     <= 1'b0;
                    read_q      <= 1'b0;
                    addr_q      <= BUS_ADDR_IDLE;
                    wdata_q     <= BUS_DATA_IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_write_q <= cmd_write_q;
                    rsp_addr_q  <= cmd_addr_q;
                    rsp_rdata_q <= cmd_write_q ? BUS_DATA_IDLE : bus.rdata;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.write     = write_q;
    assign bus.read      = read_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = (state_q != ST_IDLE) || queued;

endmodule

// File: tb/tb_timer_bus_master.sv
// Directed bench for timer_bus_master with a small timer register model as bus responder.
`timescale 1ns/1ps
module tb_timer_bus_master;

`ifdef TIMER_CMD_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    timer_bus_master_if bus ();

    timer_bus_master #(.FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Timer register model: address 11 is not decoded, reads show 8'hEE there.
    logic [7:0] mregs [4];
    always @(posedge clk) begin
        if (rst) begin
            mregs[0] <= 8'h00;
            mregs[1] <= 8'hA5;
            mregs[2] <= 8'h5A;
            mregs[3] <= 8'hEE;
        end else if (bus.write && bus.addr != 2'b11) begin
            mregs[bus.addr] <= bus.wdata;
        end
    end
    assign bus.rdata = bus.read ? mregs[bus.addr] : 8'h00;

    logic       cw   [8];
    logic [1:0] ca   [8];
    logic [7:0] cd   [8];
    logic [7:0] cexp [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [1:0] a, input logic [7:0] d);
        bus.cmd_valid = v;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
    endtask

    // Offers n commands back to back; observation ob is taken just after edge ob,
    // edge 0 being the first acceptance. Transaction k occupies ob = LAT+3k .. LAT+3k+2.
    task automatic burst(input int n, input string name);
        int idx = 0;
        int acc [8];
        int k, ph;
        logic rdy;
        for (int ob = 0; ob <= LAT + 3 * n; ob++) begin
            if (idx < n) set_cmd(1'b1, cw[idx], ca[idx], cd[idx]);
            else         set_cmd(1'b0, 1'b0, 2'b00, 8'h00);
            rdy = bus.cmd_ready;
            step();
            if (idx < n && rdy) begin
                acc[idx] = ob;
                idx++;
            end
            if (ob >= LAT && ob < LAT + 3 * n) begin
                k  = (ob - LAT) / 3;
                ph = (ob - LAT) % 3;
            end else begin
                k  = 0;
                ph = 3;
            end
            chk({name, ".write"}, bus.write, (ph == 1) && cw[k]);
            chk({name, ".read"},  bus.read,  (ph == 1) && !cw[k]);
            chk({name, ".addr"},  bus.addr,  (ph < 2) ? ca[k] : 2'b00);
            chk({name, ".wdata"}, bus.wdata, (ph < 2) ? cd[k] : 8'h00);
            chk({name, ".rsp_valid"}, bus.rsp_valid, ph == 2);
            chk({name, ".busy"}, bus.busy, ob < LAT + 3 * n);
            if (ph == 2) begin
                chk({name, ".rsp_write"}, bus.rsp_write, cw[k]);
                chk({name, ".rsp_addr"},  bus.rsp_addr,  ca[k]);
                chk({name, ".rsp_rdata"}, bus.rsp_rdata, cexp[k]);
            end
            if (LAT == 1 && n == 6 && ob == 5) chk({name, ".ready_full"}, bus.cmd_ready, 0);
        end
        chk({name, ".accepted"}, idx, n);
        for (int j = 0; j < n; j++)
            chk({name, ".accept_edge"}, acc[j], (LAT == 1) ? j : 3 * j);
    endtask

    task automatic load(input int i, input logic w, input logic [1:0] a, input logic [7:0] d, input logic [7:0] e);
        cw[i] = w; ca[i] = a; cd[i] = d; cexp[i] = e;
    endtask

    initial begin
        set_cmd(1'b0, 1'b0, 2'b00, 8'h00);
        rst = 1'b1;
        repeat (3) step();
        chk("rst.addr", bus.addr, 0);
        chk("rst.wdata", bus.wdata, 0);
        chk("rst.write", bus.write, 0);
        chk("rst.read", bus.read, 0);
        chk("rst.rsp_valid", bus.rsp_valid, 0);
        chk("rst.rsp_write", bus.rsp_write, 0);
        chk("rst.rsp_addr", bus.rsp_addr, 0);
        chk("rst.rsp_rdata", bus.rsp_rdata, 0);
        chk("rst.busy", bus.busy, 0);
        rst = 1'b0;
        #1;
        chk("rst.cmd_ready", bus.cmd_ready, 1);
        step();

        // Reset values of the three decoded registers.
        load(0, 1'b0, 2'b00, 8'h00, 8'h00);
        load(1, 1'b0, 2'b01, 8'h00, 8'hA5);
        load(2, 1'b0, 2'b10, 8'h00, 8'h5A);
        burst(3, "rd3");
        step();

        load(0, 1'b1, 2'b00, 8'h80, 8'h00);
        load(1, 1'b1, 2'b00, 8'h01, 8'h00);
        load(2, 1'b1, 2'b01, 8'h49, 8'h00);
        load(3, 1'b1, 2'b10, 8'h09, 8'h00);
        burst(4, "wr4");
        step();

        load(0, 1'b0, 2'b01, 8'h00, 8'h49);
        load(1, 1'b0, 2'b11, 8'h00, 8'hEE);
        burst(2, "rdback");
        step();

`ifdef TIMER_CMD_FIFO_EN
        load(0, 1'b1, 2'b10, 8'h33, 8'h00);
        load(1, 1'b0, 2'b10, 8'h00, 8'h33);
        load(2, 1'b1, 2'b01, 8'hC4, 8'h00);
        load(3, 1'b0, 2'b01, 8'h00, 8'hC4);
        load(4, 1'b0, 2'b00, 8'h00, 8'h01);
        load(5, 1'b0, 2'b11, 8'h00, 8'hEE);
        burst(6, "fifo6");
        step();
`endif

        // Reset during the strobe of a read, with a second command offered behind it.
        set_cmd(1'b1, 1'b0, 2'b10, 8'h00);
        step();
        set_cmd(1'b1, 1'b1, 2'b01, 8'h77);
        step();
        set_cmd(1'b0, 1'b0, 2'b00, 8'h00);
        if (LAT == 1) step();
        chk("rstmid.read_before", bus.read, 1);
        chk("rstmid.addr_before", bus.addr, 2'b10);
        rst = 1'b1;
        step();
        chk("rstmid.read", bus.read, 0);
        chk("rstmid.write", bus.write, 0);
        chk("rstmid.addr", bus.addr, 0);
        chk("rstmid.wdata", bus.wdata, 0);
        chk("rstmid.rsp_valid", bus.rsp_valid, 0);
        chk("rstmid.busy", bus.busy, 0);
        rst = 1'b0;
        #1;
        chk("rstmid.cmd_ready", bus.cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstmid.no_rsp", bus.rsp_valid, 0);
            chk("rstmid.idle_busy", bus.busy, 0);
            chk("rstmid.no_write", bus.write, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
